// File: rtl/sd_pkg.sv
// sd_pkg
//   Shared types and constants for the SD controller AXI4-Lite bridge.
//   sd_state_e : bridge FSM state encoding
//   RESP_OKAY  : AXI OKAY response code, the only response the bridge returns
//   BE_ALL     : byte enable used for full-word reads of the SD port
package sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_ISSUE = 3'd1,
      ST_WR_RESP  = 3'd2,
      ST_RD_ISSUE = 3'd3,
      ST_RD_WAIT  = 3'd4,
      ST_RD_RESP  = 3'd5
   } sd_state_e;

   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [7:0] BE_ALL    = 8'hFF;

endpackage

// File: rtl/sd_axil_bridge.sv
// sd_axil_bridge
//   AXI4-Lite slave that turns single read/write transactions into one-cycle
//   accesses on the SD controller register/buffer port. One transaction is in
//   flight at a time; simultaneous write and read requests alternate.
//
//   Parameter
//     RD_LAT        cycles from the spisd_en read cycle to valid spisd_rddata (1..4)
//   Ports
//     msoc_clk      clock
//     rstn          asynchronous active-low reset
//     s_aw*/s_w*    AXI write address / write data channels (inputs + readies)
//     s_b*          AXI write response channel
//     s_ar*         AXI read address channel
//     s_r*          AXI read data channel
//     spisd_en      one-cycle access strobe to the SD controller
//     spisd_we      write qualifier for spisd_en
//     spisd_be      byte enables of the access
//     spisd_addr    access address, held between accesses
//     spisd_wrdata  write data
//     spisd_rddata  read data returned RD_LAT cycles after the read strobe
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_IDLE     | waiting for a write pair (AW+W) or a read (AR); grants here
//   ST_WR_ISSUE | spisd write strobe cycle (suppressed when wstrb is zero)
//   ST_WR_RESP  | s_bvalid held until s_bready
//   ST_RD_ISSUE | spisd read strobe cycle
//   ST_RD_WAIT  | counting down RD_LAT cycles, samples spisd_rddata at the end
//   ST_RD_RESP  | s_rvalid held with stable s_rdata until s_rready
module sd_axil_bridge
   import sd_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic        msoc_clk,
   input  logic        rstn,

   input  logic [15:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,

   input  logic [63:0] s_wdata,
   input  logic [7:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,

   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,

   input  logic [15:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,

   output logic [63:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,

   output logic        spisd_en,
   output logic        spisd_we,
   output logic [7:0]  spisd_be,
   output logic [15:0] spisd_addr,
   output logic [63:0] spisd_wrdata,
   input  logic [63:0] spisd_rddata
);

   // Down-counter start value: terminal count 0 marks the last wait cycle.
   localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

   sd_state_e   r_state;
   logic        r_last_wr;
   logic [1:0]  r_wait_cnt;

   logic        r_spisd_en;
   logic        r_spisd_we;
   logic [7:0]  r_spisd_be;
   logic [15:0] r_spisd_addr;
   logic [63:0] r_spisd_wrdata;
   logic        r_bvalid;
   logic        r_rvalid;
   logic [63:0] r_rdata;

   logic        w_idle;
   logic        w_wr_pend;
   logic        w_rd_pend;
   logic        w_grant_wr;
   logic        w_grant_rd;

   // Readies are combinational so they can rise in the same cycle the
   // request becomes complete. rstn gates them so that reset forces them low
   // even while the valids are high.
   assign w_idle     = rstn & (r_state == ST_IDLE);
   assign w_wr_pend  = s_awvalid & s_wvalid;
   assign w_rd_pend  = s_arvalid;
   assign w_grant_wr = w_idle & w_wr_pend & (~w_rd_pend | ~r_last_wr);
   assign w_grant_rd = w_idle & w_rd_pend & ~w_grant_wr;

   assign s_awready    = w_grant_wr;
   assign s_wready     = w_grant_wr;
   assign s_arready    = w_grant_rd;

   assign s_bvalid     = r_bvalid;
   assign s_bresp      = RESP_OKAY;
   assign s_rvalid     = r_rvalid;
   assign s_rresp      = RESP_OKAY;
   assign s_rdata      = r_rdata;

   assign spisd_en     = r_spisd_en;
   assign spisd_we     = r_spisd_we;
   assign spisd_be     = r_spisd_be;
   assign spisd_addr   = r_spisd_addr;
   assign spisd_wrdata = r_spisd_wrdata;

   always_ff @(posedge msoc_clk or negedge rstn) begin
      if (!rstn) begin
         r_state        <= ST_IDLE;
         r_last_wr      <= 1'b0;
         r_wait_cnt     <= 2'd0;
         r_spisd_en     <= 1'b0;
         r_spisd_we     <= 1'b0;
         r_spisd_be     <= 8'd0;
         r_spisd_addr   <= 16'd0;
         r_spisd_wrdata <= 64'd0;
         r_bvalid       <= 1'b0;
         r_rvalid       <= 1'b0;
         r_rdata        <= 64'd0;
      end else begin
         // Strobes are single-cycle; only the grant below raises them.
         r_spisd_en <= 1'b0;
         r_spisd_we <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_grant_wr) begin
                  r_state        <= ST_WR_ISSUE;
                  r_last_wr      <= 1'b1;
                  r_spisd_en     <= |s_wstrb;
                  r_spisd_we     <= 1'b1;
                  r_spisd_be     <= s_wstrb;
                  r_spisd_addr   <= s_awaddr;
                  r_spisd_wrdata <= s_wdata;
               end else if (w_grant_rd) begin
                  r_state      <= ST_RD_ISSUE;
                  r_last_wr    <= 1'b0;
                  r_spisd_en   <= 1'b1;
                  r_spisd_we   <= 1'b0;
                  r_spisd_be   <= BE_ALL;
                  r_spisd_addr <= s_araddr;
               end
            end

            ST_WR_ISSUE: begin
               r_state  <= ST_WR_RESP;
               r_bvalid <= 1'b1;
            end

            ST_WR_RESP: begin
               if (s_bready) begin
                  r_state  <= ST_IDLE;
                  r_bvalid <= 1'b0;
               end
            end

            ST_RD_ISSUE: begin
               r_state    <= ST_RD_WAIT;
               r_wait_cnt <= WAIT_LOAD;
            end

            ST_RD_WAIT: begin
               if (r_wait_cnt == 2'd0) begin
                  r_state  <= ST_RD_RESP;
                  r_rdata  <= spisd_rddata;
                  r_rvalid <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt - 2'd1;
               end
            end

            ST_RD_RESP: begin
               if (s_rready) begin
                  r_state  <= ST_IDLE;
                  r_rvalid <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sd_axil_bridge.md
SD_AXIL_BRIDGE -- requirements
Module: sd_axil_bridge

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning cycles from the spisd_en read cycle to valid spisd_rddata; legal range 1..4.
REQ-002 SHALL have port msoc_clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports s_awaddr in 16, s_awvalid in 1, s_awready out 1: the AXI4-Lite write-address channel.
REQ-005 SHALL have ports s_wdata in 64, s_wstrb in 8, s_wvalid in 1, s_wready out 1: the AXI4-Lite write-data channel.
REQ-006 SHALL have ports s_bresp out 2, s_bvalid out 1, s_bready in 1: the AXI4-Lite write-response channel.
REQ-007 SHALL have ports s_araddr in 16, s_arvalid in 1, s_arready out 1: the AXI4-Lite read-address channel.
REQ-008 SHALL have ports s_rdata out 64, s_rresp out 2, s_rvalid out 1, s_rready in 1: the AXI4-Lite read-data channel.
REQ-009 SHALL have ports spisd_en out 1, spisd_we out 1, spisd_be out 8, spisd_addr out 16, spisd_wrdata out 64, spisd_rddata in 64: the SD controller register/buffer port.

Function
REQ-010 SHALL implement an FSM with states IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
REQ-011 In IDLE with s_awvalid and s_wvalid both high, SHALL assert s_awready and s_wready together for one cycle (never separately), latch addr/data/strb, and go to WR_ISSUE.
REQ-012 In IDLE with s_arvalid high, SHALL assert s_arready for one cycle, latch the address, and go to RD_ISSUE.
REQ-013 When a write pair and a read are both pending in IDLE, SHALL grant the type not granted last; the last-grant flag resets to read, so write wins the first tie.
REQ-014 WR_ISSUE SHALL last exactly one cycle: spisd_en=1, spisd_we=1, spisd_be=latched wstrb, spisd_wrdata=latched wdata, spisd_addr=latched awaddr; if wstrb==0, spisd_en stays 0.
REQ-015 WR_RESP SHALL hold s_bvalid=1, s_bresp=2'b00 until s_bready, then return to IDLE; write latency is handshake edge to s_bvalid = 2 cycles.
REQ-016 RD_ISSUE SHALL last one cycle with spisd_en=1, spisd_we=0, spisd_be=8'hFF, spisd_addr=latched araddr.
REQ-017 RD_WAIT SHALL count RD_LAT cycles with spisd_addr held and spisd_en=0, sample spisd_rddata at the end of the last count cycle, then enter RD_RESP.
REQ-018 RD_RESP SHALL hold s_rvalid=1, s_rresp=2'b00, s_rdata stable until s_rready, then return to IDLE.
REQ-019 Outside WR_ISSUE/RD_ISSUE, spisd_en and spisd_we SHALL be 0; spisd_addr SHALL keep its last value.
REQ-020 s_awaddr/s_araddr bits [2:0] SHALL be forwarded unchanged; no error response is generated for any address.
REQ-021 SHALL accept no new request while a transaction is outstanding (single outstanding transaction).

Reset
REQ-022 On rstn low, SHALL asynchronously force state IDLE and all ready/valid, spisd_en and spisd_we to 0, and spisd_be, spisd_addr, spisd_wrdata, s_rdata and the bresp/rresp outputs to 0.
REQ-023 Reset mid-transaction SHALL abandon it with no spisd_en pulse and no response after rstn rises.

Structure
REQ-024 The state enum and the OKAY response constant (2'b00) SHALL be in shared package sd_pkg.
REQ-025 SHALL be one flat module with no sub-module.

Verification
REQ-026 Write awaddr=16'h0028, wdata=64'h1, wstrb=8'hFF -> one-cycle spisd_en/we with addr 16'h0028; s_bvalid 2 cycles after handshake; bresp=0.
REQ-027 Read araddr=16'h8010, RD_LAT=1, spisd_rddata=64'hCAFEF00D12345678 one cycle after spisd_en -> s_rdata matches; s_rvalid held through 3 cycles of s_rready=0.
REQ-028 AW, W and AR all valid in the same cycle after reset -> write is served first, then the read; a second simultaneous tie grants read first.
REQ-029 s_awvalid high with s_wvalid low for 5 cycles -> no s_awready and no spisd_en; both readies rise in the cycle s_wvalid rises.
REQ-030 wstrb=8'h00 -> no spisd_en pulse; bvalid still asserted with bresp=0.
REQ-031 rstn asserted during RD_WAIT -> all outputs zero immediately; after release, no s_rvalid and the next read completes normally.
